clock_digit_renderer: RTL

Pixel-generation stage directly downstream of the VGA timing generator. It consumes the pixel position, the active flag and the syncs, and renders a six-digit HH:MM:SS seven-segment clock with blinking colons. Output is a 6-bit RGB pixel plus syncs, all delayed so they stay aligned with the pixel. The time value is sampled once per frame during vertical blanking, so a frame never shows a partial time update.

---
 rtl/clock_digit_renderer_if.sv | 36 +++
 rtl/clock_digit_renderer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_digit_renderer_if.sv
// -----------------------------------------------------------------------------
// clock_digit_renderer_if
// Pixel bus between the VGA timing generator / pixel sink and the digit
// renderer.
//   h_pos, v_pos       : pixel x / line y from the timing generator
//   active_in          : visible-area flag
//   hsync_in, vsync_in : syncs, active-low
//   time_bcd           : {Ht,Hu,Mt,Mu,St,Su}, 4-bit BCD each
//   rgb                : rendered pixel {R[1:0],G[1:0],B[1:0]}
//   hsync_out,
//   vsync_out,
//   active_out         : syncs / active delayed to line up with rgb
// master = timing-generator side, slave = renderer side.
// -----------------------------------------------------------------------------
interface clock_digit_renderer_if;
   logic [9:0]  h_pos;
   logic [9:0]  v_pos;
   logic        active_in;
   logic        hsync_in;
   logic        vsync_in;
   logic [23:0] time_bcd;
   logic [5:0]  rgb;
   logic        hsync_out;
   logic        vsync_out;
   logic        active_out;

   modport master (
      output h_pos, v_pos, active_in, hsync_in, vsync_in, time_bcd,
      input  rgb, hsync_out, vsync_out, active_out
   );

   modport slave (
      input  h_pos, v_pos, active_in, hsync_in, vsync_in, time_bcd,
      output rgb, hsync_out, vsync_out, active_out
   );
endinterface

// File: rtl/clock_digit_renderer.sv
// -----------------------------------------------------------------------------
// clock_digit_renderer
// Renders a six-digit HH:MM:SS seven-segment clock with blinking colons on
// top of the VGA timing stream. The time is copied into a shadow register
// once per frame (h_pos==0, v_pos==480) so a frame never shows a torn update.
// Two register stages: stage 1 finds the slot and local coordinates and picks
// the BCD digit, stage 2 does the segment hit test and colours the pixel.
// Syncs and active are delayed by the same two stages.
// Ports:
//   clk     : pixel clock
//   sys_rst : asynchronous reset, active-high
//   pix     : pixel bus (slave side), see clock_digit_renderer_if
// -----------------------------------------------------------------------------
module clock_digit_renderer #(
   parameter int         X0             = 96,
   parameter int         Y0             = 176,
   parameter int         DIGIT_W        = 64,
   parameter int         DIGIT_H        = 128,
   parameter int         SEG_T          = 12,
   parameter logic [5:0] FG_COLOR       = 6'b111100,
   parameter logic [5:0] BG_COLOR       = 6'b000001,
   parameter bit         HIDE_LEAD_ZERO = 1'b0
) (
   input  logic                 clk,
   input  logic                 sys_rst,
   clock_digit_renderer_if.slave pix
);

   // Local coordinate width: large enough for the bigger of the box sides.
   localparam int LCW   = (DIGIT_H > DIGIT_W) ? $clog2(DIGIT_H) : $clog2(DIGIT_W);
   localparam int NSLOT = 8;

   // Slot ids: 0..5 digits (Ht..Su), 6/7 colons, 8 background.
   localparam logic [3:0] SLOT_C1   = 4'd6;
   localparam logic [3:0] SLOT_C2   = 4'd7;
   localparam logic [3:0] SLOT_NONE = 4'd8;
   // Digit code used for every "draw nothing" case (10..15 are blank too).
   localparam logic [3:0] BLANK     = 4'hF;

   localparam logic signed [10:0] X0_S = 11'(X0);
   localparam logic signed [10:0] Y0_S = 11'(Y0);
   localparam logic signed [10:0] DH_S = 11'(DIGIT_H);
   localparam logic signed [10:0] DW_S = 11'(DIGIT_W);
   localparam logic signed [10:0] CW_S = 11'sd32;

   // Slot start offsets relative to X0, digits first then the two colons.
   localparam logic signed [10:0] SLOT_LO [NSLOT] = '{
      11'sd0, 11'sd72, 11'sd184, 11'sd256, 11'sd368, 11'sd440, 11'sd144, 11'sd328
   };
   localparam logic signed [10:0] SLOT_W [NSLOT] = '{
      DW_S, DW_S, DW_S, DW_S, DW_S, DW_S, CW_S, CW_S
   };

   // Segment band thresholds in local coordinates.
   localparam logic [LCW-1:0] T_L    = LCW'(SEG_T);
   localparam logic [LCW-1:0] H2_L   = LCW'(DIGIT_H / 2);
   localparam logic [LCW-1:0] G_LO_L = LCW'(DIGIT_H / 2 - SEG_T / 2);
   localparam logic [LCW-1:0] G_HI_L = LCW'(DIGIT_H / 2 + SEG_T / 2);
   localparam logic [LCW-1:0] D_LO_L = LCW'(DIGIT_H - SEG_T);
   localparam logic [LCW-1:0] R_LO_L = LCW'(DIGIT_W - SEG_T);

   // Colon dot boxes in local coordinates.
   localparam logic [LCW-1:0] DOT_X_LO  = LCW'(10);
   localparam logic [LCW-1:0] DOT_X_HI  = LCW'(22);
   localparam logic [LCW-1:0] DOT1_Y_LO = LCW'(36);
   localparam logic [LCW-1:0] DOT1_Y_HI = LCW'(48);
   localparam logic [LCW-1:0] DOT2_Y_LO = LCW'(80);
   localparam logic [LCW-1:0] DOT2_Y_HI = LCW'(92);

   // Segment set per BCD value, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_mask(input logic [3:0] digit);
      logic [6:0] m;
      case (digit)
         4'd0:    m = 7'b0111111;
         4'd1:    m = 7'b0000110;
         4'd2:    m = 7'b1011011;
         4'd3:    m = 7'b1001111;
         4'd4:    m = 7'b1100110;
         4'd5:    m = 7'b1101101;
         4'd6:    m = 7'b1111101;
         4'd7:    m = 7'b0000111;
         4'd8:    m = 7'b1111111;
         4'd9:    m = 7'b1101111;
         default: m = 7'b0000000;
      endcase
      return m;
   endfunction

   logic signed [10:0] xr_s;
   logic signed [10:0] yr_s;
   logic               in_y_s;
   logic               frame_evt_s;

   logic [23:0]    shadow_q;
   logic [5:0]     frame_cnt_q;

   logic [3:0]     slot_d,  slot_q;
   logic [LCW-1:0] lx_d,    lx_q;
   logic [LCW-1:0] ly_d,    ly_q;
   logic [3:0]     digit_d, digit_q;
   logic           hs1_q, vs1_q, act1_q;

   logic [6:0]     region_s;
   logic [6:0]     mask_s;
   logic           digit_hit_s;
   logic           colon_hit_s;
   logic           fg_s;
   logic [5:0]     rgb_d,   rgb_q;
   logic           hs2_q, vs2_q, act2_q;

   // Signed offsets keep positions left of X0 / above Y0 negative instead of
   // wrapping into a slot; h_pos beyond the visible width simply misses.
   assign xr_s        = $signed({1'b0, pix.h_pos}) - X0_S;
   assign yr_s        = $signed({1'b0, pix.v_pos}) - Y0_S;
   assign in_y_s      = (yr_s >= 11'sd0) && (yr_s < DH_S);
   assign frame_evt_s = (pix.h_pos == 10'd0) && (pix.v_pos == 10'd480);

   // Per-frame time snapshot and blink counter, both advanced on the frame event.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         shadow_q    <= 24'h000000;
         frame_cnt_q <= 6'd0;
      end else if (frame_evt_s) begin
         shadow_q    <= pix.time_bcd;
         frame_cnt_q <= frame_cnt_q + 6'd1;
      end else begin
         shadow_q    <= shadow_q;
         frame_cnt_q <= frame_cnt_q;
      end
   end

   // Locate the slot under the pixel and its local x; slots never overlap.
   always_comb begin
      slot_d = SLOT_NONE;
      lx_d   = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (in_y_s && (xr_s >= SLOT_LO[i]) && (xr_s < SLOT_LO[i] + SLOT_W[i])) begin
            slot_d = 4'(i);
            lx_d   = LCW'(xr_s - SLOT_LO[i]);
         end else begin
         end
      end
   end

   // Local y and the BCD digit that belongs to the slot (blank elsewhere).
   always_comb begin
      ly_d = in_y_s ? LCW'(yr_s) : '0;
      case (slot_d)
         4'd0:    digit_d = (HIDE_LEAD_ZERO && (shadow_q[23:20] == 4'd0)) ? BLANK : shadow_q[23:20];
         4'd1:    digit_d = shadow_q[19:16];
         4'd2:    digit_d = shadow_q[15:12];
         4'd3:    digit_d = shadow_q[11:8];
         4'd4:    digit_d = shadow_q[7:4];
         4'd5:    digit_d = shadow_q[3:0];
         default: digit_d = BLANK;
      endcase
   end

   // Stage 1 registers: slot, local coordinates, digit, first sync delay.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         slot_q  <= SLOT_NONE;
         lx_q    <= '0;
         ly_q    <= '0;
         digit_q <= BLANK;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         act1_q  <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         lx_q    <= lx_d;
         ly_q    <= ly_d;
         digit_q <= digit_d;
         hs1_q   <= pix.hsync_in;
         vs1_q   <= pix.vsync_in;
         act1_q  <= pix.active_in;
      end
   end

   // Segment hit test, colon dots and final colour selection.
   always_comb begin
      region_s[0] = (ly_q < T_L);
      region_s[1] = (lx_q >= R_LO_L) && (ly_q < H2_L);
      region_s[2] = (lx_q >= R_LO_L) && (ly_q >= H2_L);
      region_s[3] = (ly_q >= D_LO_L);
      region_s[4] = (lx_q < T_L) && (ly_q >= H2_L);
      region_s[5] = (lx_q < T_L) && (ly_q < H2_L);
      region_s[6] = (ly_q >= G_LO_L) && (ly_q < G_HI_L);
      mask_s      = seg_mask(digit_q);
      digit_hit_s = |(mask_s & region_s);
      // Dots are shown for the first half of each 64-frame blink period.
      colon_hit_s = !frame_cnt_q[5]
                  && (lx_q >= DOT_X_LO) && (lx_q < DOT_X_HI)
                  && (((ly_q >= DOT1_Y_LO) && (ly_q < DOT1_Y_HI))
                   || ((ly_q >= DOT2_Y_LO) && (ly_q < DOT2_Y_HI)));
      case (slot_q)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: fg_s = digit_hit_s;
         SLOT_C1, SLOT_C2:                   fg_s = colon_hit_s;
         default:                            fg_s = 1'b0;
      endcase
      if (act1_q) begin
         rgb_d = fg_s ? FG_COLOR : BG_COLOR;
      end else begin
         rgb_d = 6'b000000;
      end
   end

   // Stage 2 registers: pixel colour and second sync delay.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         rgb_q  <= 6'b000000;
         hs2_q  <= 1'b1;
         vs2_q  <= 1'b1;
         act2_q <= 1'b0;
      end else begin
         rgb_q  <= rgb_d;
         hs2_q  <= hs1_q;
         vs2_q  <= vs1_q;
         act2_q <= act1_q;
      end
   end

   assign pix.rgb        = rgb_q;
   assign pix.hsync_out  = hs2_q;
   assign pix.vsync_out  = vs2_q;
   assign pix.active_out = act2_q;

endmodule
